// File: rtl/fuzzy_scan_ctrl.sv
// Round-robin scheduler sharing one fuzzy risk engine between NZ zones.
// Latches zone requests, drives the engine, captures risk, keeps per-zone alarms.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   en                    scan enable (0 = no new grants)
//   zone_req[NZ]          per-zone sample-request pulses
//   zone_raw/zone_sow     8-bit rain/soil samples per zone, zone i at [8i+7:8i]
//   thr_hi/thr_lo         alarm set/clear thresholds
//   eng_raw/eng_sow       samples to engine, eng_ef evaluate strobe
//   eng_risk              registered risk returned by the engine
//   res_valid/zone/risk   one-cycle tagged result
//   alarm[NZ]             per-zone hysteresis alarm
//   ovf[NZ]               sticky: request while already pending
//   busy                  scheduler not idle
module fuzzy_scan_ctrl #(
    parameter int NZ      = 4,
    parameter int ENG_LAT = 1,
    localparam int ZW     = $clog2(NZ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NZ-1:0]    zone_req,
    input  logic [8*NZ-1:0]  zone_raw,
    input  logic [8*NZ-1:0]  zone_sow,
    input  logic [7:0]       thr_hi,
    input  logic [7:0]       thr_lo,
    output logic [7:0]       eng_raw,
    output logic [7:0]       eng_sow,
    output logic             eng_ef,
    input  logic [7:0]       eng_risk,
    output logic             res_valid,
    output logic [ZW-1:0]    res_zone,
    output logic [7:0]       res_risk,
    output logic [NZ-1:0]    alarm,
    output logic [NZ-1:0]    ovf,
    output logic             busy
);

    localparam int CW = (ENG_LAT > 2) ? $clog2(ENG_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((ENG_LAT > 1) ? ENG_LAT - 2 : 0);

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        WAIT,
        CAP
    } state_t;

    state_t          state_q, state_d;
    logic [NZ-1:0]   pend_q, pend_d;
    logic [NZ-1:0]   ovf_q, ovf_d;
    logic [ZW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      eng_raw_q, eng_raw_d;
    logic [7:0]      eng_sow_q, eng_sow_d;
    logic            eng_ef_q, eng_ef_d;
    logic            res_valid_q, res_valid_d;
    logic [ZW-1:0]   res_zone_q, res_zone_d;
    logic [7:0]      res_risk_q, res_risk_d;
    logic [NZ-1:0]   alarm_q, alarm_d;
    logic            busy_q, busy_d;

    logic [NZ-1:0]   clr;
    logic            gnt_ok;
    int              gnt;
    int              idx;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        eng_raw_d   = eng_raw_q;
        eng_sow_d   = eng_sow_q;
        eng_ef_d    = 1'b0;
        res_valid_d = 1'b0;
        res_zone_d  = res_zone_q;
        res_risk_d  = res_risk_q;
        alarm_d     = alarm_q;
        clr         = '0;
        gnt_ok      = 1'b0;
        gnt         = 0;
        idx         = 0;

        // First pending zone after the last granted one, wrapping.
        for (int k = 1; k <= NZ; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NZ) idx = idx - NZ;
            if (!gnt_ok && pend_q[idx]) begin
                gnt_ok = 1'b1;
                gnt    = idx;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (en && gnt_ok) begin
                    clr       = NZ'(1) << gnt;
                    eng_raw_d = zone_raw[8*gnt +: 8];
                    eng_sow_d = zone_sow[8*gnt +: 8];
                    last_d    = ZW'(gnt);
                    eng_ef_d  = 1'b1;
                    state_d   = FIRE;
                end
            end
            FIRE: begin
                if (ENG_LAT == 1) begin
                    state_d = CAP;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = CAP;
                else cnt_d = cnt_q - CW'(1);
            end
            CAP: begin
                res_valid_d = 1'b1;
                res_risk_d  = eng_risk;
                res_zone_d  = last_q;
                // Set wins when the thresholds overlap.
                if (eng_risk >= thr_hi) alarm_d[last_q] = 1'b1;
                else if (eng_risk <= thr_lo) alarm_d[last_q] = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A request landing on its own grant cycle re-arms without overflow.
        ovf_d  = ovf_q | (zone_req & pend_q & ~clr);
        pend_d = (pend_q & ~clr) | zone_req;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            ovf_q       <= '0;
            last_q      <= ZW'(NZ - 1);
            cnt_q       <= '0;
            eng_raw_q   <= '0;
            eng_sow_q   <= '0;
            eng_ef_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_zone_q  <= '0;
            res_risk_q  <= '0;
            alarm_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            eng_raw_q   <= eng_raw_d;
            eng_sow_q   <= eng_sow_d;
            eng_ef_q    <= eng_ef_d;
            res_valid_q <= res_valid_d;
            res_zone_q  <= res_zone_d;
            res_risk_q  <= res_risk_d;
            alarm_q     <= alarm_d;
            busy_q      <= busy_d;
        end
    end

    assign eng_raw   = eng_raw_q;
    assign eng_sow   = eng_sow_q;
    assign eng_ef    = eng_ef_q;
    assign res_valid = res_valid_q;
    assign res_zone  = res_zone_q;
    assign res_risk  = res_risk_q;
    assign alarm     = alarm_q;
    assign ovf       = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fuzzy_scan_ctrl.sv
// Testbench for fuzzy_scan_ctrl: table-driven single-zone scans plus
// round-robin, overflow, enable-drop and asynchronous-reset sequences.
module tb_fuzzy_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] zone_raw = '0;
    logic [31:0] zone_sow = '0;
    logic [7:0]  thr_hi = 8'd200;
    logic [7:0]  thr_lo = 8'd100;

    logic        en1 = 1'b0;
    logic [3:0]  req1 = '0;
    logic [7:0]  eng_raw1, eng_sow1, eng_risk1, res_risk1;
    logic        eng_ef1, res_valid1, busy1;
    logic [1:0]  res_zone1;
    logic [3:0]  alarm1, ovf1;

    logic        en3 = 1'b0;
    logic [3:0]  req3 = '0;
    logic [7:0]  eng_raw3, eng_sow3, eng_risk3, res_risk3;
    logic        eng_ef3, res_valid3, busy3;
    logic [1:0]  res_zone3;
    logic [3:0]  alarm3, ovf3;
    logic [7:0]  p0, p1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fuzzy_scan_ctrl #(.NZ(4), .ENG_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .zone_req(req1),
        .zone_raw(zone_raw), .zone_sow(zone_sow),
        .thr_hi(thr_hi), .thr_lo(thr_lo),
        .eng_raw(eng_raw1), .eng_sow(eng_sow1), .eng_ef(eng_ef1),
        .eng_risk(eng_risk1), .res_valid(res_valid1),
        .res_zone(res_zone1), .res_risk(res_risk1),
        .alarm(alarm1), .ovf(ovf1), .busy(busy1)
    );

    fuzzy_scan_ctrl #(.NZ(4), .ENG_LAT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .zone_req(req3),
        .zone_raw(zone_raw), .zone_sow(zone_sow),
        .thr_hi(thr_hi), .thr_lo(thr_lo),
        .eng_raw(eng_raw3), .eng_sow(eng_sow3), .eng_ef(eng_ef3),
        .eng_risk(eng_risk3), .res_valid(res_valid3),
        .res_zone(res_zone3), .res_risk(res_risk3),
        .alarm(alarm3), .ovf(ovf3), .busy(busy3)
    );

    // Engine model: 85 * min(3, (raw+sow)/40), registered on ef.
    function automatic logic [7:0] eng_f(logic [7:0] r, logic [7:0] s);
        int q;
        q = (int'(r) + int'(s)) / 40;
        if (q > 3) q = 3;
        return 8'(85 * q);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_risk1 <= '0;
            p0 <= '0;
            p1 <= '0;
            eng_risk3 <= '0;
        end else begin
            if (eng_ef1) eng_risk1 <= eng_f(eng_raw1, eng_sow1);
            if (eng_ef3) p0 <= eng_f(eng_raw3, eng_sow3);
            p1 <= p0;
            eng_risk3 <= p1;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         zone;
        logic [7:0] raw;
        logic [7:0] sow;
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] risk;
        logic [3:0] alarm;
    } vec_t;

    vec_t tbl[11];

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req1 = '0;
        req3 = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(vec_t v, int n);
        int efs;
        int lat;
        thr_hi = v.hi;
        thr_lo = v.lo;
        zone_raw = {4{8'hFF}};
        zone_sow = {4{8'hFF}};
        zone_raw[8*v.zone +: 8] = v.raw;
        zone_sow[8*v.zone +: 8] = v.sow;
        @(negedge clk);
        req1 = 4'b0001 << v.zone;
        @(negedge clk);
        req1 = '0;
        efs = 0;
        lat = 0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (eng_ef1) begin
                efs++;
                chk($sformatf("v%0d_eng_raw", n), 32'(eng_raw1), 32'(v.raw));
                chk($sformatf("v%0d_eng_sow", n), 32'(eng_sow1), 32'(v.sow));
            end
            if (res_valid1) lat = c;
        end
        chk($sformatf("v%0d_lat", n), 32'(lat), 32'd3);
        chk($sformatf("v%0d_ef_cnt", n), 32'(efs), 32'd1);
        chk($sformatf("v%0d_zone", n), 32'(res_zone1), 32'(v.zone));
        chk($sformatf("v%0d_risk", n), 32'(res_risk1), 32'(v.risk));
        chk($sformatf("v%0d_alarm", n), 32'(alarm1), 32'(v.alarm));
        @(negedge clk);
        chk($sformatf("v%0d_pulse", n), 32'(res_valid1), 32'd0);
    endtask

    initial begin
        logic [7:0] rr_risk [4];
        int k;
        int lat;
        int cnt;

        tbl[0]  = '{2, 8'd80, 8'd80, 8'd200, 8'd100, 8'd255, 4'b0100};
        tbl[1]  = '{2, 8'd20, 8'd20, 8'd200, 8'd100, 8'd85,  4'b0000};
        tbl[2]  = '{2, 8'd80, 8'd80, 8'd200, 8'd100, 8'd255, 4'b0100};
        tbl[3]  = '{2, 8'd50, 8'd50, 8'd200, 8'd100, 8'd170, 4'b0100};
        tbl[4]  = '{0, 8'd50, 8'd50, 8'd200, 8'd100, 8'd170, 4'b0100};
        tbl[5]  = '{0, 8'd20, 8'd20, 8'd200, 8'd100, 8'd85,  4'b0100};
        tbl[6]  = '{0, 8'd50, 8'd50, 8'd170, 8'd100, 8'd170, 4'b0101};
        tbl[7]  = '{0, 8'd50, 8'd50, 8'd200, 8'd170, 8'd170, 4'b0100};
        tbl[8]  = '{3, 8'd20, 8'd20, 8'd80,  8'd90,  8'd85,  4'b1100};
        tbl[9]  = '{1, 8'd0,  8'd0,  8'd0,   8'd0,   8'd0,   4'b1110};
        tbl[10] = '{3, 8'd0,  8'd0,  8'd200, 8'd0,   8'd0,   4'b0110};
        rr_risk = '{8'd0, 8'd85, 8'd170, 8'd255};

        // Reset state
        @(negedge clk);
        chk("rst_ef", 32'(eng_ef1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_valid", 32'(res_valid1), 32'd0);
        chk("rst_alarm", 32'(alarm1), 32'd0);
        chk("rst_ovf", 32'(ovf1), 32'd0);
        chk("rst_raw", 32'(eng_raw1), 32'd0);
        chk("rst_zone", 32'(res_zone1), 32'd0);
        chk("rst3_busy", 32'(busy3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        en1 = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(tbl[i], i);

        // Round robin over all four zones, starting at zone 0.
        do_reset();
        zone_raw = {8'd120, 8'd80, 8'd40, 8'd0};
        zone_sow = '0;
        thr_hi = 8'd255;
        thr_lo = 8'd0;
        req1 = 4'b1111;
        @(negedge clk);
        req1 = '0;
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (eng_ef1) chk("rr_busy", 32'(busy1), 32'd1);
            if (res_valid1 && k < 4) begin
                chk($sformatf("rr%0d_zone", k), 32'(res_zone1), 32'(k));
                chk($sformatf("rr%0d_risk", k), 32'(res_risk1), 32'(rr_risk[k]));
                chk($sformatf("rr%0d_cyc", k), 32'(c), 32'(3 * (k + 1)));
                k++;
            end
        end
        chk("rr_count", 32'(k), 32'd4);

        // Overflow: second request while zone 1 still pending.
        do_reset();
        en1 = 1'b0;
        req1 = 4'b0010;
        @(negedge clk);
        req1 = '0;
        @(negedge clk);
        chk("ovf_first", 32'(ovf1), 32'd0);
        req1 = 4'b0010;
        @(negedge clk);
        req1 = '0;
        @(negedge clk);
        chk("ovf_set", 32'(ovf1), 32'b0010);

        // Request on its own grant cycle: re-pends, no overflow.
        do_reset();
        en1 = 1'b1;
        req1 = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        req1 = '0;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (res_valid1) begin
                cnt++;
                chk("repend_zone", 32'(res_zone1), 32'd1);
            end
        end
        chk("repend_count", 32'(cnt), 32'd2);
        chk("repend_ovf", 32'(ovf1), 32'd0);

        // ENG_LAT=3, enable dropped during WAIT.
        do_reset();
        en1 = 1'b0;
        zone_raw = {8'd0, 8'd20, 8'd0, 8'd80};
        zone_sow = {8'd0, 8'd20, 8'd0, 8'd80};
        en3 = 1'b1;
        req3 = 4'b0101;
        @(negedge clk);
        req3 = '0;
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) chk("l3_ef", 32'(eng_ef3), 32'd1);
            if (c == 2) en3 = 1'b0;
            if (res_valid3) lat = c;
        end
        chk("l3_lat", 32'(lat), 32'd5);
        chk("l3_zone", 32'(res_zone3), 32'd0);
        chk("l3_risk", 32'(res_risk3), 32'd255);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (res_valid3 || eng_ef3 || busy3) cnt++;
        end
        chk("l3_hold", 32'(cnt), 32'd0);
        en3 = 1'b1;
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(negedge clk);
            if (res_valid3) lat = c;
        end
        chk("l3_resume_lat", 32'(lat), 32'd5);
        chk("l3_resume_zone", 32'(res_zone3), 32'd2);
        chk("l3_resume_risk", 32'(res_risk3), 32'd85);
        en3 = 1'b0;

        // Asynchronous reset in the middle of FIRE.
        do_reset();
        en1 = 1'b1;
        zone_raw = {4{8'd80}};
        zone_sow = {4{8'd80}};
        thr_hi = 8'd200;
        thr_lo = 8'd100;
        req1 = 4'b0100;
        @(negedge clk);
        req1 = '0;
        cnt = 0;
        for (int c = 0; c < 4 && cnt == 0; c++) begin
            @(negedge clk);
            if (eng_ef1) cnt = 1;
        end
        chk("ar_reach_fire", 32'(cnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ef", 32'(eng_ef1), 32'd0);
        chk("ar_busy", 32'(busy1), 32'd0);
        chk("ar_raw", 32'(eng_raw1), 32'd0);
        chk("ar_sow", 32'(eng_sow1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (res_valid1 || eng_ef1) cnt++;
        end
        chk("ar_no_result", 32'(cnt), 32'd0);
        chk("ar_alarm", 32'(alarm1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
